// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants and types for the register-file write scheduler.
// Source indices double as round-robin slot numbers and pointer values.
package regfile_write_scheduler_pkg;

   typedef logic [3:0] reg_idx_t;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'd0,
      SRC_MEM  = 2'd1,
      SRC_LINK = 2'd2
   } src_t;

   localparam int unsigned PC_INDEX   = 15;
   localparam int unsigned LINK_INDEX = 14;

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter3.sv
// Three-way combinational round-robin arbiter; the search starts at the
// source after ptr and wraps after LINK.
module rr_arbiter3
   import regfile_write_scheduler_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] grant
);

   always_comb begin
      grant = '0;
      case (ptr)
         SRC_ALU: begin
            if (req[SRC_MEM])       grant[SRC_MEM]  = 1'b1;
            else if (req[SRC_LINK]) grant[SRC_LINK] = 1'b1;
            else if (req[SRC_ALU])  grant[SRC_ALU]  = 1'b1;
         end
         SRC_MEM: begin
            if (req[SRC_LINK])      grant[SRC_LINK] = 1'b1;
            else if (req[SRC_ALU])  grant[SRC_ALU]  = 1'b1;
            else if (req[SRC_MEM])  grant[SRC_MEM]  = 1'b1;
         end
         // LINK and the unused encoding both restart the search at ALU
         default: begin
            if (req[SRC_ALU])       grant[SRC_ALU]  = 1'b1;
            else if (req[SRC_MEM])  grant[SRC_MEM]  = 1'b1;
            else if (req[SRC_LINK]) grant[SRC_LINK] = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates ALU / load / link writebacks onto the single register-file
// write port and tracks outstanding writes for decode stalls.
module regfile_write_scheduler #(
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned PC_INDEX   = regfile_write_scheduler_pkg::PC_INDEX,
   parameter int unsigned LINK_INDEX = regfile_write_scheduler_pkg::LINK_INDEX
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                alu_req,
   input  logic [3:0]          alu_dest,
   input  logic [31:0]         alu_data,
   input  logic                mem_req,
   input  logic [3:0]          mem_dest,
   input  logic [31:0]         mem_data,
   input  logic                link_req,
   input  logic [31:0]         link_data,
   output logic                alu_grant,
   output logic                mem_grant,
   output logic                link_grant,
   input  logic                issue_valid,
   input  logic [3:0]          issue_dest,
   output logic                writeEnable,
   output logic [3:0]          writeDestination,
   output logic [31:0]         writeData,
   output logic                writeToPC,
   output logic [NUM_REGS-1:0] pending
);

   import regfile_write_scheduler_pkg::*;

   localparam reg_idx_t PC_IDX   = reg_idx_t'(PC_INDEX);
   localparam reg_idx_t LINK_IDX = reg_idx_t'(LINK_INDEX);

   src_t                last_grant;
   logic [2:0]          arb_grant;
   logic [2:0]          grant;
   logic                any_grant;
   reg_idx_t            sel_dest;
   logic [31:0]         sel_data;
   logic [NUM_REGS-1:0] pending_next;

   rr_arbiter3 u_arb (
      .req   ({link_req, mem_req, alu_req}),
      .ptr   (last_grant),
      .grant (arb_grant)
   );

   // Grants are suppressed for the whole time reset is held low
   assign grant      = arb_grant & {3{reset}};
   assign alu_grant  = grant[SRC_ALU];
   assign mem_grant  = grant[SRC_MEM];
   assign link_grant = grant[SRC_LINK];
   assign any_grant  = |grant;

   always_comb begin
      sel_dest = alu_dest;
      sel_data = alu_data;
      if (grant[SRC_MEM]) begin
         sel_dest = mem_dest;
         sel_data = mem_data;
      end else if (grant[SRC_LINK]) begin
         sel_dest = LINK_IDX;
         sel_data = link_data;
      end
   end

   // Clear first, then set, so a same-register issue keeps the bit high
   always_comb begin
      pending_next = pending;
      if (any_grant)   pending_next[sel_dest]   = 1'b0;
      if (issue_valid) pending_next[issue_dest] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         writeEnable      <= 1'b0;
         writeDestination <= '0;
         writeData        <= '0;
         writeToPC        <= 1'b0;
         pending          <= '0;
         last_grant       <= SRC_LINK;
      end else begin
         writeEnable <= any_grant;
         writeToPC   <= any_grant && (sel_dest == PC_IDX);
         if (any_grant) begin
            writeDestination <= sel_dest;
            writeData        <= sel_data;
         end
         if (grant[SRC_ALU])       last_grant <= SRC_ALU;
         else if (grant[SRC_MEM])  last_grant <= SRC_MEM;
         else if (grant[SRC_LINK]) last_grant <= SRC_LINK;
         pending <= pending_next;
      end
   end

endmodule
